// File: rtl/fetch_unit.sv
// fetch_unit
// Instruction fetch stage. Fetches 64-byte lines over the Sysbus
// request/response interface into a one-line buffer and hands sequential
// 32-bit instructions to decode over a valid/ready handshake. Downstream
// redirects move the PC and either hit the buffered line or start a refetch.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   entry                 PC loaded while reset is asserted
//   redirect_valid/_pc    redirect request and target (bits [1:0] ignored)
//   inst_valid/_ready     decode handshake
//   inst, inst_pc         instruction word and its address
//   bus_reqcyc/_req/_reqtag/_reqack   line read request channel
//   bus_respcyc/_respack/_resp/_resptag response beat channel (tag ignored)
//
// The line is 8 beats of BUS_DATA_WIDTH; instruction extraction assumes
// 64-bit beats (two instructions per beat, even word in the low half).
module fetch_unit #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter logic [BUS_TAG_WIDTH-1:0] READ_TAG = 13'h1100
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [63:0]               entry,
  input  logic                      redirect_valid,
  input  logic [63:0]               redirect_pc,
  output logic                      inst_valid,
  input  logic                      inst_ready,
  output logic [31:0]               inst,
  output logic [63:0]               inst_pc,
  output logic                      bus_reqcyc,
  output logic [63:0]               bus_req,
  output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  input  logic                      bus_reqack,
  input  logic                      bus_respcyc,
  output logic                      bus_respack,
  input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    RESP  = 2'd2,
    SERVE = 2'd3
  } state_t;

  state_t state, state_next;

  // Control state (reset)
  logic [63:0] pc;
  logic        line_ok;
  logic        stale;
  logic [2:0]  beat;
  logic        bubble;

  // Data state (no reset; qualified by line_ok / state)
  logic [63:0]               req_addr;
  logic [57:0]               line_tag;
  logic [BUS_DATA_WIDTH-1:0] line_buf [8];

  logic [63:0]               redirect_al;
  logic                      hit_pc;
  logic                      hit_redirect;
  logic                      handshake;
  logic                      last_beat;
  logic                      line_end;
  logic                      refetch;
  logic [BUS_DATA_WIDTH-1:0] cur_beat;
  logic                      unused_inputs;

  assign unused_inputs = ^{bus_resptag, entry[1:0], redirect_pc[1:0]};

  assign redirect_al  = {redirect_pc[63:2], 2'b00};
  assign hit_pc       = line_ok && (pc[63:6] == line_tag);
  assign hit_redirect = line_ok && (redirect_al[63:6] == line_tag);

  // A redirect in the same cycle overrides the decode handshake.
  assign handshake = (state == SERVE) && !bubble && inst_ready && !redirect_valid;
  assign line_end  = (pc[5:2] == 4'hF);
  assign last_beat = (state == RESP) && bus_respcyc && (beat == 3'd7);
  // A line is thrown away if a redirect arrived during the transaction or
  // coincides with its final beat.
  assign refetch   = stale || redirect_valid;

  assign cur_beat = line_buf[pc[5:3]];

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    inst_valid  = 1'b0;
    inst        = '0;
    inst_pc     = '0;
    bus_reqcyc  = 1'b0;
    bus_req     = '0;
    bus_reqtag  = '0;
    bus_respack = 1'b0;
    case (state)
      IDLE: begin
        if (redirect_valid) begin
          state_next = hit_redirect ? SERVE : IDLE;
        end else begin
          state_next = hit_pc ? SERVE : REQ;
        end
      end
      REQ: begin
        bus_reqcyc = 1'b1;
        bus_req    = req_addr;
        bus_reqtag = READ_TAG;
        if (bus_reqack) begin
          state_next = RESP;
        end
      end
      RESP: begin
        bus_respack = bus_respcyc;
        if (last_beat) begin
          state_next = refetch ? REQ : SERVE;
        end
      end
      SERVE: begin
        // The cycle right after a redirect is a bubble.
        inst_valid = !bubble;
        inst       = pc[2] ? cur_beat[32 +: 32] : cur_beat[31:0];
        inst_pc    = pc;
        if (redirect_valid) begin
          state_next = hit_redirect ? SERVE : IDLE;
        end else if (handshake && line_end) begin
          state_next = REQ;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc      <= {entry[63:2], 2'b00};
      line_ok <= 1'b0;
      stale   <= 1'b0;
      beat    <= 3'd0;
      bubble  <= 1'b0;
    end else begin
      bubble <= redirect_valid;
      if (redirect_valid) begin
        pc <= redirect_al;
      end else if (handshake) begin
        pc <= pc + 64'd4;
      end
      case (state)
        REQ: begin
          if (redirect_valid) begin
            stale <= 1'b1;
          end
          if (bus_reqack) begin
            beat    <= 3'd0;
            line_ok <= 1'b0;
          end
        end
        RESP: begin
          if (bus_respcyc) begin
            beat <= beat + 3'd1;
          end
          if (last_beat) begin
            if (refetch) begin
              stale <= 1'b0;
            end else begin
              line_ok <= 1'b1;
            end
          end else if (redirect_valid) begin
            stale <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    case (state)
      IDLE: begin
        if (!redirect_valid && !hit_pc) begin
          req_addr <= {pc[63:6], 6'b0};
        end
      end
      RESP: begin
        if (bus_respcyc) begin
          line_buf[beat] <= bus_resp;
        end
        if (last_beat) begin
          if (refetch) begin
            // Refetch from wherever the PC now points (including a redirect
            // landing in this same cycle).
            req_addr <= redirect_valid ? {redirect_al[63:6], 6'b0} : {pc[63:6], 6'b0};
          end else begin
            line_tag <= req_addr[63:6];
          end
        end
      end
      SERVE: begin
        // Line after the last word; wraps modulo 2^64.
        if (handshake && line_end) begin
          req_addr <= {pc[63:6] + 58'd1, 6'b0};
        end
      end
      default: ;
    endcase
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage feeding decode in the core top level.
- Fetches 64-byte aligned lines over the Sysbus request/response interface and buffers one line.
- Presents sequential 32-bit instructions to decode through a valid/ready handshake.
- Accepts redirects (branch/jump targets) from downstream.

Parameters:
BUS_DATA_WIDTH, 64, width of bus_req / bus_resp; the line is 8 beats of this width
BUS_TAG_WIDTH, 13, width of bus_reqtag / bus_resptag
READ_TAG, 13'h1100, tag driven on bus_reqtag for a memory read (READ at bit 12, MEMORY in bits 11:8)

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
entry  input  64  PC loaded at reset
redirect_valid  input  1  redirect request this cycle
redirect_pc  input  64  new PC; bits [1:0] ignored, treated as 0
inst_valid  output  1  inst/inst_pc are valid
inst_ready  input  1  decode accepts the instruction this cycle
inst  output  32  instruction word
inst_pc  output  64  address of inst
bus_reqcyc  output  1  bus request valid
bus_req  output  64  request address, line aligned
bus_reqtag  output  13  request tag, always READ_TAG
bus_reqack  input  1  request accepted
bus_respcyc  input  1  response beat valid
bus_respack  output  1  response beat consumed
bus_resp  input  64  response data
bus_resptag  input  13  response tag, ignored

Behaviour:
- Interface: one clock `clk`; `reset` is synchronous and active-high.
- State registers: pc, req_addr, line_buf (8x64), line_tag (pc[63:6] of the buffered line), line_ok, beat counter (3 bits), stale flag.
- States: IDLE, REQ, RESP, SERVE.
- On reset:
  - pc <= {entry[63:2],2'b0}; state IDLE; line_ok=0; stale=0; beat=0.
  - All outputs 0 (inst_valid, bus_reqcyc, bus_respack, bus_req, bus_reqtag, inst, inst_pc).
- IDLE:
  - If line_ok and pc[63:6]==line_tag, go to SERVE.
  - Otherwise latch req_addr <= {pc[63:6],6'b0} and go to REQ.
- REQ:
  - bus_reqcyc=1, bus_req=req_addr, bus_reqtag=READ_TAG; held stable until bus_reqack.
  - On the bus_reqack cycle: go to RESP, clear beat counter, line_ok <= 0.
  - A request is never withdrawn once asserted.
- RESP:
  - bus_respack = bus_respcyc (combinational).
  - Each beat with respcyc writes line_buf[beat] <= bus_resp and increments beat.
  - Beats arrive in ascending address order from the line base.
  - On the 8th beat:
    - stale=0: line_tag <= req_addr[63:6]; line_ok <= 1; go to SERVE.
    - stale=1: clear stale, latch req_addr from the current pc, go to REQ. The line is discarded and line_ok stays 0.
- SERVE:
  - inst_valid=1; inst = 32-bit word pc[5:2] of line_buf (word 2k = low half of beat k); inst_pc = pc.
  - On inst_valid & inst_ready: pc <= pc+4.
  - If pc[5:2]==15 on that handshake, the next line is needed: latch req_addr <= {pc[63:6]+1,6'b0} and go to REQ.
  - inst_valid deasserts from the next cycle.
- Latency:
  - Miss to first inst_valid: 1 cycle after the bus_reqack cycle plus 8 beat cycles; inst_valid rises the cycle after the 8th beat.
  - Sequential in-line instructions: 1 per cycle.
- Redirect (highest priority; the handshake in the same cycle is ignored and pc does not advance):
  - pc <= redirect_pc with bits [1:0] cleared.
  - In SERVE or IDLE: on a line hit (line_ok and tag match) go to SERVE next cycle; otherwise go to IDLE.
  - In REQ or RESP: set stale; the bus transaction is completed and all 8 beats are drained and acked.
  - inst_valid is 0 in the cycle after a redirect.
- Simultaneous redirect and last beat in RESP: treated as stale; the line is discarded and a refetch is issued.
- Reset mid-transaction: state and line are cleared; bus_reqcyc and bus_respack drop the next cycle. Beats arriving afterward are not acked.
- Wrap-around: pc arithmetic is modulo 2^64; the line after 0xFFFF_FFFF_FFFF_FFC0 is 0x0.

Test Plan:
- Cold fetch:
  - Stimulus: entry=0x1000, reqack after 2 cycles, beats 0x1..0x8.
  - Required: bus_req=0x1000, tag=0x1100.
  - First inst_pc=0x1000, inst=0x00000001.
  - Second inst=0x00000000.
- Sequential run:
  - Stimulus: inst_ready=1 through 16 instructions.
  - Required: inst_pc 0x1000..0x103C one per cycle.
  - Then a REQ with bus_req=0x1040, and inst_valid=0 until its 8 beats return.
- Backpressure: inst_ready=0 for 5 cycles → inst/inst_pc held stable, pc unchanged.
- Redirect hit: redirect_pc=0x1023 while serving line 0x1000 → no bus request; next inst_pc=0x1020.
- Redirect during RESP:
  - Stimulus: redirect_pc=0x2000 at beat 3.
  - Required: remaining 5 beats acked; then REQ bus_req=0x2000; first inst_pc=0x2000.
  - No instruction from line 0x1000 is issued after the redirect.
- Reset mid-REQ: reset while reqcyc=1 and no ack → bus_reqcyc=0 the next cycle; refetch from entry after reset is released.
